irq_controller: RTL and testbench



---
 rtl/irq_pkg.sv | 12 +
 rtl/irq_pri_enc8.sv | 22 ++
 rtl/irq_controller.sv | 92 +++++++++
 tb/tb_irq_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt request controller.
package irq_pkg;

  localparam int unsigned IRQ_N   = 8;
  localparam int unsigned IRQ_IDW = 3;

  typedef enum logic {
    IRQ_IDLE   = 1'b0,
    IRQ_ACTIVE = 1'b1
  } irq_state_t;

endpackage

// File: rtl/irq_pri_enc8.sv
// Combinational 8-to-3 highest-index priority encoder with an any-set flag.
module irq_pri_enc8
  import irq_pkg::*;
(
  input  logic [IRQ_N-1:0]   req,
  output logic [IRQ_IDW-1:0] id,
  output logic               any
);

  // Ascending scan: the last set bit seen is the highest index, which wins.
  always_comb begin
    id  = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < IRQ_N; i++) begin
      if (req[i]) begin
        id  = IRQ_IDW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Eight-input interrupt controller: pending capture, software mask, and a
// valid/ack handshake that holds the presented ID stable until acknowledged.
module irq_controller
  import irq_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_N-1:0]   irq_in,
  input  logic               mask_wr,
  input  logic [IRQ_N-1:0]   mask_in,
  input  logic               irq_ack,
  output logic               irq_valid,
  output logic [IRQ_IDW-1:0] irq_id,
  output logic [IRQ_N-1:0]   pending,
  output logic [IRQ_N-1:0]   mask
);

  irq_state_t         state;
  irq_state_t         state_nxt;
  logic [IRQ_N-1:0]   irq_q;
  logic [IRQ_N-1:0]   req;
  logic [IRQ_N-1:0]   set_vec;
  logic [IRQ_N-1:0]   clr_vec;
  logic [IRQ_IDW-1:0] enc_id;
  logic               enc_any;
  logic               load_id;
  logic               ack_fire;

  assign req = pending & ~mask;

  irq_pri_enc8 u_enc (
    .req (req),
    .id  (enc_id),
    .any (enc_any)
  );

  // Capture vector: rising edges or levels, depending on EDGE.
  always_comb begin
    set_vec = EDGE ? (irq_in & ~irq_q) : irq_in;
  end

  // Clear vector: one-hot of the presented ID on an accepted ack.
  always_comb begin
    clr_vec = '0;
    if (ack_fire) clr_vec[irq_id] = 1'b1;
  end

  // Next-state and ID-load decode for the handshake FSM.
  always_comb begin
    state_nxt = state;
    load_id   = 1'b0;
    ack_fire  = 1'b0;
    case (state)
      IRQ_IDLE: begin
        if (enc_any) begin
          state_nxt = IRQ_ACTIVE;
          load_id   = 1'b1;
        end
      end
      IRQ_ACTIVE: begin
        if (irq_ack) begin
          state_nxt = IRQ_IDLE;
          ack_fire  = 1'b1;
        end
      end
      default: state_nxt = IRQ_IDLE;
    endcase
  end

  // State, ID, pending, mask and input history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IRQ_IDLE;
      irq_id  <= '0;
      pending <= '0;
      mask    <= '0;
      irq_q   <= '0;
    end else begin
      state   <= state_nxt;
      irq_q   <= irq_in;
      // Set is OR-ed after the clear so a same-cycle re-request survives the ack.
      pending <= (pending & ~clr_vec) | set_vec;
      if (load_id) irq_id <= enc_id;
      if (mask_wr) mask   <= mask_in;
    end
  end

  assign irq_valid = (state == IRQ_ACTIVE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (EDGE=1).
module tb_irq_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_in;
  logic       irq_ack;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] mask;

  int unsigned vectors;
  int unsigned miscompares;

  irq_controller #(.EDGE(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask_wr   (mask_wr),
    .mask_in   (mask_in),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .mask      (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] id,
                         input logic [7:0] p);
    chk({tag, ".valid"}, {7'd0, irq_valid}, {7'd0, v});
    if (v) chk({tag, ".id"}, {5'd0, irq_id}, {5'd0, id});
    chk({tag, ".pending"}, pending, p);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic wr_mask(input logic [7:0] m);
    mask_wr = 1'b1;
    mask_in = m;
    tick();
    mask_wr = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    irq_in  = '0;
    mask_wr = 1'b0;
    mask_in = '0;
    irq_ack = 1'b0;

    // Reset state
    #12;
    chk("rst.valid", {7'd0, irq_valid}, 8'h00);
    chk("rst.id", {5'd0, irq_id}, 8'h00);
    chk("rst.pending", pending, 8'h00);
    chk("rst.mask", mask, 8'h00);
    rst_n = 1'b1;
    tick();

    // Single request: two edges to valid
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    chk_out("single.E0", 1'b0, 3'd0, 8'h10);
    tick();
    chk_out("single.E1", 1'b1, 3'd4, 8'h10);
    ack();
    chk_out("single.ack", 1'b0, 3'd0, 8'h00);

    // Priority ordering 7, 3, 0 with one idle cycle between
    irq_in = 8'h89;
    tick();
    irq_in = 8'h00;
    chk_out("prio.E0", 1'b0, 3'd0, 8'h89);
    tick();
    chk_out("prio.id7", 1'b1, 3'd7, 8'h89);
    ack();
    chk_out("prio.gap1", 1'b0, 3'd0, 8'h09);
    tick();
    chk_out("prio.id3", 1'b1, 3'd3, 8'h09);
    ack();
    chk_out("prio.gap2", 1'b0, 3'd0, 8'h01);
    tick();
    chk_out("prio.id0", 1'b1, 3'd0, 8'h01);
    ack();
    chk_out("prio.done", 1'b0, 3'd0, 8'h00);
    tick();
    chk_out("prio.idle", 1'b0, 3'd0, 8'h00);

    // Mask: masked bit still pends but is not selected
    wr_mask(8'h80);
    chk("mask.reg80", mask, 8'h80);
    irq_in = 8'h81;
    tick();
    irq_in = 8'h00;
    chk_out("mask.E0", 1'b0, 3'd0, 8'h81);
    tick();
    chk_out("mask.id0", 1'b1, 3'd0, 8'h81);
    ack();
    chk_out("mask.ack0", 1'b0, 3'd0, 8'h80);
    tick();
    chk_out("mask.held", 1'b0, 3'd0, 8'h80);
    wr_mask(8'h00);
    chk("mask.reg00", mask, 8'h00);
    chk_out("mask.wr_edge", 1'b0, 3'd0, 8'h80);
    tick();
    chk_out("mask.id7", 1'b1, 3'd7, 8'h80);
    ack();
    chk_out("mask.ack7", 1'b0, 3'd0, 8'h00);

    // Stability: ID frozen across a new request and a mask change
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    tick();
    chk_out("stab.id2", 1'b1, 3'd2, 8'h04);
    irq_in  = 8'h40;
    mask_wr = 1'b1;
    mask_in = 8'h04;
    tick();
    irq_in  = 8'h00;
    mask_wr = 1'b0;
    chk_out("stab.hold1", 1'b1, 3'd2, 8'h44);
    chk("stab.mask", mask, 8'h04);
    tick();
    chk_out("stab.hold2", 1'b1, 3'd2, 8'h44);
    ack();
    chk_out("stab.ack2", 1'b0, 3'd0, 8'h40);
    tick();
    chk_out("stab.id6", 1'b1, 3'd6, 8'h40);
    ack();
    chk_out("stab.ack6", 1'b0, 3'd0, 8'h00);
    wr_mask(8'h00);

    // Set beats clear on the same bit
    irq_in = 8'h20;
    tick();
    irq_in = 8'h00;
    tick();
    chk_out("svc.id5", 1'b1, 3'd5, 8'h20);
    irq_in  = 8'h20;
    irq_ack = 1'b1;
    tick();
    irq_in  = 8'h00;
    irq_ack = 1'b0;
    chk_out("svc.ack", 1'b0, 3'd0, 8'h20);
    tick();
    chk_out("svc.re5", 1'b1, 3'd5, 8'h20);
    ack();
    chk_out("svc.done", 1'b0, 3'd0, 8'h00);

    // Asynchronous reset mid-ACTIVE; held line re-pends after release
    irq_in = 8'h08;
    tick();
    tick();
    chk_out("arst.id3", 1'b1, 3'd3, 8'h08);
    wr_mask(8'h02);
    chk("arst.mask", mask, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", {7'd0, irq_valid}, 8'h00);
    chk("arst.pending", pending, 8'h00);
    chk("arst.mask0", mask, 8'h00);
    chk("arst.id", {5'd0, irq_id}, 8'h00);
    tick();
    chk_out("arst.held", 1'b0, 3'd0, 8'h00);
    rst_n = 1'b1;
    tick();
    chk_out("arst.repend", 1'b0, 3'd0, 8'h08);
    tick();
    chk_out("arst.reid3", 1'b1, 3'd3, 8'h08);
    irq_in = 8'h00;
    ack();
    chk_out("arst.done", 1'b0, 3'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
